// File: rtl/lut_shr_bus_if.sv
// Bus bundle for lut_shr_bus: shift/flush/tap-read controls toward the buffer,
// data, fill state and validity flags back toward the requester.
interface lut_shr_bus_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              sh_en;
  logic [WIDTH-1:0]  din;
  logic              clr;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  q_msb;
  logic              q_msb_vld;
  logic [WIDTH-1:0]  q_sel;
  logic              q_sel_vld;
  logic [CNT_W-1:0]  fill;
  logic              full;

  modport master (
    output sh_en, din, clr, rd_en, addr,
    input  q_msb, q_msb_vld, q_sel, q_sel_vld, fill, full
  );

  modport slave (
    input  sh_en, din, clr, rd_en, addr,
    output q_msb, q_msb_vld, q_sel, q_sel_vld, fill, full
  );
endinterface

// File: rtl/lut_shr_bus.sv
// Multi-bit addressable shift-register history buffer with fill tracking,
// a registered random-access tap and a full-qualified oldest-stage output.
module lut_shr_bus #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input logic         clk,
  input logic         rst,
  lut_shr_bus_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  // Storage is deliberately never reset so it can map onto LUT shift registers.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_nxt;
  logic             full_q;
  logic [WIDTH-1:0] q_sel_q;
  logic             q_sel_vld_q;
  logic             addr_in_range;
  logic             addr_valid;

  // A flush on a shifting edge drops old entries first, then counts the new word.
  always_comb begin
    fill_nxt = fill_q;
    if (bus.clr) begin
      fill_nxt = bus.sh_en ? CNT_W'(1) : '0;
    end else if (bus.sh_en && (fill_q != FILL_MAX)) begin
      fill_nxt = fill_q + CNT_W'(1);
    end
  end

  assign addr_in_range = CNT_W'(bus.addr) < FILL_MAX;
  assign addr_valid    = CNT_W'(bus.addr) < fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= '0;
      full_q      <= 1'b0;
      q_sel_q     <= '0;
      q_sel_vld_q <= 1'b0;
    end else begin
      if (bus.sh_en) begin
        mem[0] <= bus.din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          mem[ADDR_W'(i)] <= mem[ADDR_W'(i - 1)];
        end
      end
      fill_q <= fill_nxt;
      full_q <= (fill_nxt == FILL_MAX);
      // Tap sees pre-shift contents and validity against pre-flush fill.
      if (bus.rd_en) begin
        q_sel_q     <= addr_in_range ? mem[bus.addr] : '0;
        q_sel_vld_q <= addr_in_range && addr_valid;
      end else begin
        q_sel_vld_q <= 1'b0;
      end
    end
  end

  assign bus.q_msb     = mem[DEPTH-1];
  assign bus.q_msb_vld = full_q;
  assign bus.q_sel     = q_sel_q;
  assign bus.q_sel_vld = q_sel_vld_q;
  assign bus.fill      = fill_q;
  assign bus.full      = full_q;
endmodule
